wb_stage: RTL and testbench



---
 rtl/wb_pkg.sv | 10 +
 rtl/wb_load_fifo.sv | 55 +++++
 rtl/wb_stage.sv | 130 +++++++++++++
 tb/tb_wb_stage.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared widths for the writeback stage.
// Build with WB_SCOREBOARD_EN defined to enable the load scoreboard.
package wb_pkg;
  localparam int WB_LEN_WORD     = 32;
  localparam int WB_LEN_REG_ADDR = 5;

  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction
endpackage

// File: rtl/wb_load_fifo.sv
// Circular buffer of {rd, data} load results.
// Power-of-two depth, so pointers wrap on overflow.
module wb_load_fifo
  import wb_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int AW    = WB_LEN_REG_ADDR,
  parameter int DW    = WB_LEN_WORD
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [AW-1:0] push_rd,
  input  logic [DW-1:0] push_data,
  input  logic          pop,
  output logic          full,
  output logic          empty,
  output logic [AW-1:0] head_rd,
  output logic [DW-1:0] head_data
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = cnt_w(DEPTH);

  logic [AW-1:0] rd_q   [DEPTH];
  logic [DW-1:0] data_q [DEPTH];
  logic [PW-1:0] wp;
  logic [PW-1:0] rp;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop)  rp <= rp + 1'b1;
      cnt <= cnt + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      rd_q[wp]   <= push_rd;
      data_q[wp] <= push_data;
    end
  end

  assign full      = (cnt == CW'(DEPTH));
  assign empty     = (cnt == '0);
  assign head_rd   = rd_q[rp];
  assign head_data = data_q[rp];

endmodule

// File: rtl/wb_stage.sv
// Writeback arbiter: ALU results vs queued loads, with starvation throttle.
// WB_SCOREBOARD_EN adds the busy-register scoreboard driving stall.
module wb_stage
  import wb_pkg::*;
#(
  parameter int LEN_WORD     = WB_LEN_WORD,
  parameter int LEN_REG_ADDR = WB_LEN_REG_ADDR,
  parameter int LQ_DEPTH     = 2,
  parameter int STARVE_MAX   = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    alu_valid,
  input  logic [LEN_REG_ADDR-1:0] alu_rd,
  input  logic [LEN_WORD-1:0]     alu_data,
  output logic                    alu_hold,
  input  logic                    ld_valid,
  output logic                    ld_ready,
  input  logic [LEN_REG_ADDR-1:0] ld_rd,
  input  logic [LEN_WORD-1:0]     ld_data,
  input  logic                    iss_valid,
  input  logic [LEN_REG_ADDR-1:0] iss_rd,
  input  logic [LEN_REG_ADDR-1:0] chk_rs1,
  input  logic [LEN_REG_ADDR-1:0] chk_rs2,
  output logic                    stall,
  output logic [LEN_REG_ADDR-1:0] ard,
  output logic [LEN_WORD-1:0]     drd
);

  localparam int SW = cnt_w(STARVE_MAX);

  logic                    lq_full;
  logic                    lq_empty;
  logic [LEN_REG_ADDR-1:0] head_rd;
  logic [LEN_WORD-1:0]     head_data;
  logic                    push;
  logic                    pop;
  logic [LEN_REG_ADDR-1:0] sel_rd;
  logic [LEN_WORD-1:0]     sel_data;
  logic [SW-1:0]           starve_q;
  logic [SW-1:0]           starve_d;

  // No pass-through: a full queue refuses even on a dequeue cycle.
  assign ld_ready = ~rst & ~lq_full;
  assign push     = ld_valid & ld_ready & (ld_rd != '0);
  assign pop      = ~alu_valid & ~lq_empty;

  wb_load_fifo #(
    .DEPTH (LQ_DEPTH),
    .AW    (LEN_REG_ADDR),
    .DW    (LEN_WORD)
  ) u_lq (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_rd   (ld_rd),
    .push_data (ld_data),
    .pop       (pop),
    .full      (lq_full),
    .empty     (lq_empty),
    .head_rd   (head_rd),
    .head_data (head_data)
  );

  always_comb begin
    sel_rd   = '0;
    sel_data = '0;
    unique case (1'b1)
      alu_valid: begin
        sel_rd   = alu_rd;
        sel_data = alu_data;
      end
      pop: begin
        sel_rd   = head_rd;
        sel_data = head_data;
      end
      default: ;
    endcase
  end

  always_comb begin
    starve_d = '0;
    if (alu_valid & ~lq_empty) begin
      if (starve_q == SW'(STARVE_MAX)) starve_d = starve_q;
      else                             starve_d = starve_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ard      <= '0;
      drd      <= '0;
      starve_q <= '0;
      alu_hold <= 1'b0;
    end else begin
      ard      <= sel_rd;
      drd      <= sel_data;
      starve_q <= starve_d;
      alu_hold <= (starve_d == SW'(STARVE_MAX));
    end
  end

`ifdef WB_SCOREBOARD_EN
  localparam int NREG = 1 << LEN_REG_ADDR;

  logic [NREG-1:0] busy_q;
  logic [NREG-1:0] set_v;
  logic [NREG-1:0] clr_v;

  always_comb begin
    set_v = '0;
    clr_v = '0;
    if (iss_valid) set_v[iss_rd]  = 1'b1;
    if (pop)       clr_v[head_rd] = 1'b1;
  end

  // Set after clear so a same-cycle reissue keeps the bit; x0 never busy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) busy_q <= '0;
    else     busy_q <= ((busy_q & ~clr_v) | set_v) & ~NREG'(1);
  end

  assign stall = busy_q[chk_rs1] | busy_q[chk_rs2];
`else
  wire unused_sb = ^{iss_valid, iss_rd, chk_rs1, chk_rs2};

  assign stall = 1'b0;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Randomized bench for wb_stage against a queue-based reference model.
// Compile with WB_SCOREBOARD_EN to also score stall behaviour.
module tb_wb_stage;
  localparam int LQ_DEPTH   = 2;
  localparam int STARVE_MAX = 4;
`ifdef WB_SCOREBOARD_EN
  localparam bit SB = 1'b1;
`else
  localparam bit SB = 1'b0;
`endif

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] d;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        alu_hold;
  logic        ld_valid;
  logic        ld_ready;
  logic [4:0]  ld_rd;
  logic [31:0] ld_data;
  logic        iss_valid;
  logic [4:0]  iss_rd;
  logic [4:0]  chk_rs1;
  logic [4:0]  chk_rs2;
  logic        stall;
  logic [4:0]  ard;
  logic [31:0] drd;

  wb_stage #(
    .LEN_WORD     (32),
    .LEN_REG_ADDR (5),
    .LQ_DEPTH     (LQ_DEPTH),
    .STARVE_MAX   (STARVE_MAX)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .alu_valid (alu_valid),
    .alu_rd    (alu_rd),
    .alu_data  (alu_data),
    .alu_hold  (alu_hold),
    .ld_valid  (ld_valid),
    .ld_ready  (ld_ready),
    .ld_rd     (ld_rd),
    .ld_data   (ld_data),
    .iss_valid (iss_valid),
    .iss_rd    (iss_rd),
    .chk_rs1   (chk_rs1),
    .chk_rs2   (chk_rs2),
    .stall     (stall),
    .ard       (ard),
    .drd       (drd)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  ent_t        mq[$];
  int          starve;
  bit [31:0]   mbusy;
  logic [4:0]  e_ard;
  logic [31:0] e_drd;
  bit          e_hold;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    starve = 0;
    mbusy  = '0;
    e_ard  = '0;
    e_drd  = '0;
    e_hold = 1'b0;
  endtask

  task automatic idle();
    alu_valid = 1'b0;
    alu_rd    = '0;
    alu_data  = '0;
    ld_valid  = 1'b0;
    ld_rd     = '0;
    ld_data   = '0;
    iss_valid = 1'b0;
    iss_rd    = '0;
  endtask

  // Called at a negedge with inputs applied; checks, steps model, waits.
  task automatic tick();
    ent_t e;
    bit   rdy;
    bit   emp;
    #1;
    check("ard", ard, e_ard);
    if (e_ard != 0) check("drd", drd, e_drd);
    check("alu_hold", alu_hold, e_hold);
    check("ld_ready", ld_ready, mq.size() != LQ_DEPTH);
    check("stall", stall, SB & (mbusy[chk_rs1] | mbusy[chk_rs2]));
    assert (!(iss_valid && iss_rd != 0 && mbusy[iss_rd]))
      else $error("issue to busy rd %0d", iss_rd);
    rdy = (mq.size() != LQ_DEPTH);
    emp = (mq.size() == 0);
    if (alu_valid) begin
      e_ard  = alu_rd;
      e_drd  = alu_data;
      starve = emp ? 0 : ((starve < STARVE_MAX) ? starve + 1 : STARVE_MAX);
    end else if (!emp) begin
      e        = mq.pop_front();
      e_ard    = e.rd;
      e_drd    = e.d;
      mbusy[e.rd] = 1'b0;
      starve   = 0;
    end else begin
      e_ard  = '0;
      starve = 0;
    end
    if (ld_valid && rdy && ld_rd != 0) begin
      e.rd = ld_rd;
      e.d  = ld_data;
      mq.push_back(e);
    end
    if (iss_valid && iss_rd != 0) mbusy[iss_rd] = 1'b1;
    e_hold = (starve == STARVE_MAX);
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst     = 1'b1;
    chk_rs1 = '0;
    chk_rs2 = '0;
    idle();
    model_reset();
    @(negedge clk);
    @(negedge clk);
    #1;
    check("rst_ld_ready", ld_ready, 1'b0);
    check("rst_drd", drd, 32'h0);
    rst = 1'b0;
    @(negedge clk);

    // Queue two loads behind the ALU, then reset mid-stream.
    alu_valid = 1; alu_rd = 1; alu_data = 32'h11;
    ld_valid = 1; ld_rd = 3; ld_data = 32'h33;
    tick();
    alu_rd = 2; alu_data = 32'h22; ld_rd = 4; ld_data = 32'h44;
    tick();
    idle();
    rst = 1'b1;
    #1;
    check("mid_rst_ard", ard, 5'd0);
    check("mid_rst_drd", drd, 32'h0);
    check("mid_rst_hold", alu_hold, 1'b0);
    check("mid_rst_ready", ld_ready, 1'b0);
    check("mid_rst_stall", stall, 1'b0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) tick();

    // Single ALU write.
    alu_valid = 1; alu_rd = 5; alu_data = 32'h1234;
    tick();
    idle();
    #1;
    check("alu5_ard", ard, 5'd5);
    check("alu5_drd", drd, 32'h1234);
    tick();
    tick();

    // Load with scoreboard hazard.
    iss_valid = 1; iss_rd = 7;
    tick();
    idle();
    chk_rs1 = 7;
    ld_valid = 1; ld_rd = 7; ld_data = 32'hDEAD;
    tick();
    idle();
    tick();
    #1;
    check("ld7_ard", ard, 5'd7);
    check("ld7_drd", drd, 32'hDEAD);
    check("ld7_stall", stall, 1'b0);
    tick();
    chk_rs1 = 0;

    // Starvation: two loads stuck behind a continuous ALU stream.
    alu_valid = 1; alu_rd = 1; alu_data = 32'hA;
    ld_valid = 1; ld_rd = 10; ld_data = 32'h10;
    tick();
    ld_rd = 11; ld_data = 32'h11;
    tick();
    ld_valid = 0;
    for (int i = 0; i < 10; i++) begin
      alu_valid = !alu_hold;
      alu_rd    = 5'd2;
      alu_data  = i;
      tick();
    end
    idle();
    repeat (3) tick();

    // Same-cycle set and clear on x9, plus a discarded x0 load.
    alu_valid = 1; alu_rd = 1; alu_data = 32'h1;
    ld_valid = 1; ld_rd = 9; ld_data = 32'h99;
    tick();
    idle();
    iss_valid = 1; iss_rd = 9; chk_rs1 = 9;
    tick();
    idle();
    #1;
    check("setclr_ard", ard, 5'd9);
    check("setclr_stall", stall, SB);
    ld_valid = 1; ld_rd = 0; ld_data = 32'hBAD;
    tick();
    idle();
    repeat (3) tick();
    chk_rs1 = 0;

    // Queue held full with ld_valid high while ALU competes.
    for (int i = 0; i < 24; i++) begin
      alu_valid = !alu_hold;
      alu_rd    = 5'($urandom_range(1, 31));
      alu_data  = $urandom;
      ld_valid  = 1;
      ld_rd     = 5'($urandom_range(1, 31));
      ld_data   = $urandom;
      tick();
    end
    idle();
    repeat (4) tick();

    // Random traffic.
    for (int i = 0; i < 2000; i++) begin
      alu_valid = ($urandom_range(0, 2) != 0) && !alu_hold;
      if ($urandom_range(0, 49) == 0) alu_valid = 1;
      alu_rd    = 5'($urandom_range(0, 31));
      alu_data  = $urandom;
      ld_valid  = $urandom_range(0, 1);
      ld_rd     = ($urandom_range(0, 9) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      ld_data   = $urandom;
      iss_rd    = 5'($urandom_range(0, 31));
      iss_valid = ($urandom_range(0, 3) == 0) && !mbusy[iss_rd];
      chk_rs1   = 5'($urandom_range(0, 31));
      chk_rs2   = 5'($urandom_range(0, 31));
      tick();
    end
    idle();
    repeat (4) tick();

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
